// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the async FIFO (r_clk domain): issues RAM reads against the
// synced write pointer and presents words through a 2-entry first-word-fall-through buffer.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  r_clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
  output logic                  r_en,
  output logic [ADDR_WIDTH-1:0] r_adrs,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PW = ADDR_WIDTH + 1;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0]         rptr_bin;
  logic [PW-1:0]         rptr_inc;
  logic [PW-1:0]         wptr_bin;
  logic                  ram_empty;
  logic                  inflight;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  logic                  pop;
  logic [2:0]            pending;
  logic                  has_slot;

  always_comb begin
    wptr_bin  = gray2bin(wptr_gray_sync);
    ram_empty = (rptr_bin == wptr_bin);
    rptr_inc  = rptr_bin + PW'(1);
    out_valid = (occ != 2'd0);
    out_data  = slot0;
    pop       = out_valid & out_ready;
    // Words already owned (buffered + in flight) minus the one leaving this cycle.
    pending   = {1'b0, occ} + {2'b00, inflight};
    has_slot  = pending < (3'd2 + {2'b00, pop});
    r_en      = !reset && !ram_empty && has_slot;
    r_adrs    = rptr_bin[ADDR_WIDTH-1:0];
    empty     = ram_empty && !inflight && (occ == 2'd0);
  end

  // Stage p0 -> p1: pointer advance and read-in-flight flag
  always_ff @(posedge r_clk) begin
    if (reset) begin
      rptr_bin  <= '0;
      rptr_gray <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= r_en;
      if (r_en) begin
        rptr_bin  <= rptr_inc;
        rptr_gray <= bin2gray(rptr_inc);
      end
    end
  end

  // Stage p1 -> p2: capture returning RAM data into the output buffer
  always_ff @(posedge r_clk) begin
    if (reset) begin
      occ   <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) slot0 <= ram_rdata;
          else             slot1 <= ram_rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            slot0 <= slot1;
            slot1 <= ram_rdata;
          end else begin
            slot0 <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
